mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL use one clock and synchronous active-high reset; ports are listed below with clock and reset first.
REQ-002 SHALL have: Clk  input  1  system clock, all state updates on posedge.
REQ-003 SHALL have: Rst  input  1  synchronous active-high reset.
REQ-004 SHALL have: req_valid  input  1  core presents an access request.
REQ-005 SHALL have: req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have: req_kind  input  2  access kind: 00 fetch, 01 load, 10 store, 11 illegal.
REQ-007 SHALL have: funct3  input  3  RISC-V width code (LB/LH/LW/LBU/LHU, SB/SH/SW); ignored for fetch.
REQ-008 SHALL have: addr  input  32  byte address.
REQ-009 SHALL have: wdata  input  32  store data, right-aligned.
REQ-010 SHALL have: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have: rsp_data  output  32  fetched instruction or extended load data; 0 for stores and errors.
REQ-012 SHALL have: err  output  1  completion was misaligned or illegal; valid with rsp_valid.
REQ-013 SHALL have: mem_addr  output  32  word address to memory, {addr[31:2],2'b00}.
REQ-014 SHALL have: mem_wd  output  32  merged write word to memory.
REQ-015 SHALL have: mem_we  output  1  memory write enable.
REQ-016 SHALL have: mem_rdata  input  32  combinational data-word read from memory.
REQ-017 SHALL have: mem_inst  input  32  combinational instruction-word read from memory.

Function
REQ-018 SHALL implement states IDLE, ACCESS, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL, on req_valid in IDLE, register kind/funct3/addr/wdata; legal and aligned requests go to ACCESS, others go to RESP with err=1.
REQ-020 SHALL treat as error: kind 11; fetch with addr[1:0]!=0; LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-021 SHALL in ACCESS drive mem_addr from the registered address and capture mem_rdata (or mem_inst for fetch) at the clock edge; fetch/load then go to RESP, store goes to WRITE.
REQ-022 SHALL in WRITE assert mem_we for exactly one cycle with mem_wd equal to the captured word with only the addressed byte lanes replaced by wdata (SB: lane addr[1:0]; SH: lanes addr[1]*2 and +1; SW: all lanes), then go to RESP.
REQ-023 SHALL in RESP assert rsp_valid for one cycle and return to IDLE; no back-pressure on responses.
REQ-024 SHALL extend loads: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; fetch returns mem_inst unmodified.
REQ-025 SHALL give latency from accept edge to rsp_valid: fetch/load 2 cycles, store 3 cycles, error 1 cycle.
REQ-026 SHALL keep mem_we=0 in every state except WRITE and whenever Rst=1.
REQ-027 SHALL ignore req_valid outside IDLE; a request held across busy cycles is accepted on the next IDLE cycle.

Reset
REQ-028 SHALL on Rst go to IDLE at the next edge: req_ready=1, rsp_valid=0, err=0, rsp_data=0, mem_we=0, mem_addr=0, mem_wd=0, and all captured registers cleared.
REQ-029 SHALL abort any in-flight access on Rst with no memory write and no response, including when Rst coincides with WRITE.

Structure
REQ-030 SHALL place kind codes, funct3 codes, and the state encoding in shared package mem_access_pkg.
REQ-031 SHALL factor lane extraction and lane merge into one combinational sub-module mem_byte_lane.

Verification
REQ-032 SHALL cover: word 0x18 = 0x00000064, LBU at 0x18 -> rsp_data=0x00000064, err=0, rsp_valid two cycles after accept.
REQ-033 SHALL cover: SB wdata=0x000000AB at 0x19 over word 0x00000064 -> one mem_we pulse with mem_wd=0x0000AB64; a following LW at 0x18 returns 0x0000AB64.
REQ-034 SHALL cover: SB 0x80 at 0x20, then LB 0x20 -> 0xFFFFFF80 and LBU 0x20 -> 0x00000080.
REQ-035 SHALL cover: LH at 0x19 and fetch at 0x22 -> err=1, rsp_data=0, mem_we never asserted, rsp_valid one cycle after accept.
REQ-036 SHALL cover: fetch at 0x20 with mem_inst=0xFEDFF28C -> rsp_data=0xFEDFF28C.
REQ-037 SHALL cover: Rst asserted during WRITE of SW 0xDEADBEEF at 0x00 (word holds 10) -> word still 10, no rsp_valid, req_ready=1 the cycle after.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared kind/funct3 codes, FSM encoding and request legality check for the memory access unit.
// Purely declarative; no timing or flow-control behaviour of its own.
package mem_access_pkg;

    typedef enum logic [1:0] {
        KIND_FETCH   = 2'b00,
        KIND_LOAD    = 2'b01,
        KIND_STORE   = 2'b10,
        KIND_ILLEGAL = 2'b11
    } kind_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } state_t;

    // True when the request can never touch memory: bad kind, bad width code or misaligned.
    function automatic logic isError(kind_t kind, logic [2:0] f3, logic [1:0] addrLo);
        logic e;
        e = 1'b0;
        case (kind)
            KIND_FETCH: e = (addrLo != 2'b00);
            KIND_LOAD: begin
                case (f3)
                    F3_B, F3_BU: e = 1'b0;
                    F3_H, F3_HU: e = addrLo[0];
                    F3_W:        e = (addrLo != 2'b00);
                    default:     e = 1'b1;
                endcase
            end
            KIND_STORE: begin
                case (f3)
                    F3_B:    e = 1'b0;
                    F3_H:    e = addrLo[0];
                    F3_W:    e = (addrLo != 2'b00);
                    default: e = 1'b1;
                endcase
            end
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, response and memory-side signals of the memory access unit.
// Request side is valid/ready; responses and memory reads have no back-pressure.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] mem_inst;

    modport master (
        output req_valid, req_kind, funct3, addr, wdata, mem_rdata, mem_inst,
        input  req_ready, rsp_valid, rsp_data, err, mem_addr, mem_wd, mem_we
    );

    modport slave (
        input  req_valid, req_kind, funct3, addr, wdata, mem_rdata, mem_inst,
        output req_ready, rsp_valid, rsp_data, err, mem_addr, mem_wd, mem_we
    );

endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane extraction with sign/zero extension and store-lane merge; combinational, zero latency.
// No flow control: outputs follow inputs.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addrLo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        laneByte   = word[{addrLo, 3'b000} +: 8];
        laneHalf   = word[{addrLo[1], 4'b0000} +: 16];
        loadData   = word;
        mergedWord = word;

        case (funct3)
            F3_B:    loadData = {{24{laneByte[7]}}, laneByte};
            F3_BU:   loadData = {24'd0, laneByte};
            F3_H:    loadData = {{16{laneHalf[15]}}, laneHalf};
            F3_HU:   loadData = {16'd0, laneHalf};
            default: loadData = word;
        endcase

        // Unaddressed lanes keep the word read during ACCESS.
        case (funct3)
            F3_B:    mergedWord[{addrLo, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    mergedWord[{addrLo[1], 4'b0000} +: 16] = wdata[15:0];
            default: mergedWord = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle fetch/load/store unit: fetch/load 2 cycles, store 3 (read-modify-write), error 1.
// req_ready only in IDLE; responses are a one-cycle pulse with no back-pressure.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic               Clk,
    input  logic               Rst,
    mem_access_unit_if.slave   bus
);

    state_t      state;
    state_t      nextState;
    kind_t       kindReg;
    logic [2:0]  funct3Reg;
    logic [31:0] addrReg;
    logic [31:0] wdataReg;
    logic [31:0] wordReg;
    logic        errReg;
    logic        reqErr;
    logic [31:0] loadData;
    logic [31:0] mergedWord;

    assign reqErr = isError(kind_t'(bus.req_kind), bus.funct3, bus.addr[1:0]);

    mem_byte_lane u_lane (
        .word       (wordReg),
        .addrLo     (addrReg[1:0]),
        .funct3     (funct3Reg),
        .wdata      (wdataReg),
        .loadData   (loadData),
        .mergedWord (mergedWord)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            kindReg   <= KIND_FETCH;
            funct3Reg <= '0;
            addrReg   <= '0;
            wdataReg  <= '0;
            wordReg   <= '0;
            errReg    <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                kindReg   <= kind_t'(bus.req_kind);
                funct3Reg <= bus.funct3;
                addrReg   <= bus.addr;
                wdataReg  <= bus.wdata;
                errReg    <= reqErr;
            end
            if (state == ACCESS) begin
                wordReg <= (kindReg == KIND_FETCH) ? bus.mem_inst : bus.mem_rdata;
            end
        end
    end

    always_comb begin
        nextState     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.err       = 1'b0;
        bus.rsp_data  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wd    = '0;
        bus.mem_addr  = {addrReg[31:2], 2'b00};

        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    nextState = reqErr ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                nextState = (kindReg == KIND_STORE) ? WRITE : RESP;
            end
            WRITE: begin
                // Reset in the same cycle must suppress the write, not just the response.
                bus.mem_we = !Rst;
                bus.mem_wd = mergedWord;
                nextState  = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.err       = errReg;
                if (!errReg) begin
                    case (kindReg)
                        KIND_FETCH: bus.rsp_data = wordReg;
                        KIND_LOAD:  bus.rsp_data = loadData;
                        default:    bus.rsp_data = '0;
                    endcase
                end
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random requests against a word-array reference model of the memory access unit.
module tb_mem_access_unit;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    logic [31:0] dmem   [0:63];
    logic [31:0] imem   [0:63];
    logic [31:0] refMem [0:63];
    logic        preload;
    logic [5:0]  preIdx;
    logic [31:0] preVal;

    int checks = 0;
    int errors = 0;

    assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];
    assign bus.mem_inst  = imem[bus.mem_addr[7:2]];

    always @(posedge Clk) begin
        if (preload) dmem[preIdx] <= preVal;
        else if (bus.mem_we === 1'b1) dmem[bus.mem_addr[7:2]] <= bus.mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour computed byte by byte from the access rules.
    task automatic modelReq(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic expErr, output logic [31:0] expData,
                            output int expLat, output logic expWe, output logic [31:0] expWd);
        int off, idx, size;
        bit sgn;
        logic [31:0] w, v, mask;
        off = int'(a[1:0]);
        idx = int'(a[7:2]);
        w = refMem[idx];
        expErr = 1'b0; expData = '0; expLat = 2; expWe = 1'b0; expWd = '0;
        size = 4; sgn = 1'b0;
        case (kind)
            2'd0: begin
                expErr = (off != 0);
                expData = imem[idx];
            end
            2'd1, 2'd2: begin
                case (f3)
                    3'd0: begin size = 1; sgn = 1'b1; end
                    3'd1: begin size = 2; sgn = 1'b1; end
                    3'd2: size = 4;
                    3'd4: size = 1;
                    3'd5: size = 2;
                    default: expErr = 1'b1;
                endcase
                if (kind == 2'd2 && f3[2]) expErr = 1'b1;
                if (off % size != 0) expErr = 1'b1;
                if (kind == 2'd1) begin
                    v = w >> (8 * off);
                    if (size < 4) begin
                        mask = (32'd1 << (8 * size)) - 32'd1;
                        v = v & mask;
                        if (sgn && v[8 * size - 1]) v = v | ~mask;
                    end
                    expData = v;
                end else begin
                    v = w;
                    for (int i = 0; i < size; i++) v[8 * (off + i) +: 8] = wd[8 * i +: 8];
                    expWd = v; expWe = 1'b1; expLat = 3; expData = '0;
                end
            end
            default: expErr = 1'b1;
        endcase
        if (expErr) begin
            expData = '0; expLat = 1; expWe = 1'b0; expWd = '0;
        end else if (expWe) begin
            refMem[idx] = expWd;
        end
    endtask

    task automatic doReq(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input string tag, output logic [31:0] gotData);
        logic expErr, expWe, gotErr, done;
        logic [31:0] expData, expWd, wdSeen;
        int expLat, lat, weSeen, idx;
        modelReq(kind, f3, a, wd, expErr, expData, expLat, expWe, expWd);
        idx = int'(a[7:2]);
        @(negedge Clk);
        check({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_kind = kind; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        @(posedge Clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; weSeen = 0; wdSeen = '0; gotData = '0; gotErr = 1'b0; done = 1'b0;
        while (!done && lat < 8) begin
            @(negedge Clk);
            lat++;
            if (lat == 1) begin
                check({tag, " busy"}, {31'd0, bus.req_ready}, 32'd0);
                if (!expErr) check({tag, " addr"}, bus.mem_addr, {a[31:2], 2'b00});
            end
            if (bus.mem_we === 1'b1) begin weSeen++; wdSeen = bus.mem_wd; end
            if (bus.rsp_valid === 1'b1) begin done = 1'b1; gotData = bus.rsp_data; gotErr = bus.err; end
        end
        check({tag, " latency"}, 32'(lat), 32'(expLat));
        check({tag, " err"}, {31'd0, gotErr}, {31'd0, expErr});
        check({tag, " data"}, gotData, expData);
        check({tag, " we count"}, 32'(weSeen), expWe ? 32'd1 : 32'd0);
        if (expWe) check({tag, " wd"}, wdSeen, expWd);
        @(negedge Clk);
        check({tag, " pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, " mem"}, dmem[idx], refMem[idx]);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  k;
        logic [2:0]  f;
        logic [31:0] a;
        Rst = 1'b1; preload = 1'b0; preIdx = '0; preVal = '0;
        bus.req_valid = 1'b0; bus.req_kind = '0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        imem[8] = 32'hFEDFF28C;
        repeat (2) @(posedge Clk);
        for (int i = 0; i < 64; i++) begin
            @(negedge Clk);
            preload = 1'b1;
            preIdx = 6'(i);
            preVal = (i == 6) ? 32'h00000064 : (i == 0) ? 32'd10 : $urandom;
            refMem[i] = preVal;
        end
        @(negedge Clk);
        preload = 1'b0;
        check("rst ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst err", {31'd0, bus.err}, 32'd0);
        check("rst rsp_data", bus.rsp_data, 32'd0);
        check("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst mem_wd", bus.mem_wd, 32'd0);
        Rst = 1'b0;

        doReq(2'd1, 3'd4, 32'h18, 32'h0, "lbu18", d);
        check("lbu18 value", d, 32'h00000064);
        doReq(2'd2, 3'd0, 32'h19, 32'hAB, "sb19", d);
        check("sb19 word", dmem[6], 32'h0000AB64);
        doReq(2'd1, 3'd2, 32'h18, 32'h0, "lw18", d);
        check("lw18 value", d, 32'h0000AB64);
        doReq(2'd2, 3'd0, 32'h20, 32'h80, "sb20", d);
        doReq(2'd1, 3'd0, 32'h20, 32'h0, "lb20", d);
        check("lb20 value", d, 32'hFFFFFF80);
        doReq(2'd1, 3'd4, 32'h20, 32'h0, "lbu20", d);
        check("lbu20 value", d, 32'h00000080);
        doReq(2'd1, 3'd1, 32'h19, 32'h0, "lh19 misaligned", d);
        doReq(2'd0, 3'd0, 32'h22, 32'h0, "fetch22 misaligned", d);
        doReq(2'd0, 3'd0, 32'h20, 32'h0, "fetch20", d);
        check("fetch20 value", d, 32'hFEDFF28C);
        doReq(2'd3, 3'd2, 32'h40, 32'h0, "illegal kind", d);
        doReq(2'd2, 3'd3, 32'h40, 32'h1234, "bad store f3", d);

        // Reset lands while the SW is in its write cycle.
        @(negedge Clk);
        bus.req_valid = 1'b1; bus.req_kind = 2'd2; bus.funct3 = 3'd2; bus.addr = 32'h0; bus.wdata = 32'hDEADBEEF;
        @(posedge Clk);
        #1 bus.req_valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("abort we before rst", {31'd0, bus.mem_we}, 32'd1);
        Rst = 1'b1;
        #1 check("abort we during rst", {31'd0, bus.mem_we}, 32'd0);
        @(negedge Clk);
        check("abort rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("abort ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort word", dmem[0], 32'd10);
        Rst = 1'b0;
        @(negedge Clk);
        check("abort no late rsp", {31'd0, bus.rsp_valid}, 32'd0);
        check("abort word later", dmem[0], 32'd10);

        for (int n = 0; n < 60; n++) begin
            k = 2'($urandom_range(0, 3));
            f = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            doReq(k, f, a, $urandom, $sformatf("rand%0d", n), d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
